// File: rtl/cmos_capture.sv
// Byte-to-RGB565 capture front end for a parallel CMOS sensor, with frame skip and geometry checking.
// Optional build macro CMOS_CAPTURE_BYTESWAP_EN packs pixels as {second byte, first byte}.
module cmos_capture #(
  parameter int FRAME_SKIP = 10,
  parameter int H_ACTIVE   = 480,
  parameter int V_ACTIVE   = 272
) (
  input  logic        cmos_pclk,
  input  logic        rst_n,
  input  logic        cfg_done,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_db,
  output logic [15:0] pdata_o,
  output logic        de_o,
  output logic        frame_start_o,
  output logic        frame_valid_o,
  output logic        geom_err_o
);

  localparam logic [15:0] SKIP_N = 16'(FRAME_SKIP);
  localparam logic [10:0] H_N    = 11'(H_ACTIVE);
  localparam logic [9:0]  V_N    = 10'(V_ACTIVE);

  typedef enum logic [1:0] {WAIT_CFG, SKIP, ARMED, CAPTURE} state_t;

  function automatic logic [15:0] pack_px(input logic [7:0] first_b, input logic [7:0] second_b);
`ifdef CMOS_CAPTURE_BYTESWAP_EN
    return {second_b, first_b};
`else
    return {first_b, second_b};
`endif
  endfunction

  state_t      state_q, state_d;
  logic        cfg_meta_q, cfg_meta_d, cfg_sync_q, cfg_sync_d;
  logic        vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic        hr_q, hr_d, hr_prev_q, hr_prev_d;
  logic [7:0]  db_q, db_d;
  logic [7:0]  byte0_q, byte0_d;
  logic        phase_q, phase_d;
  logic [15:0] skip_cnt_q, skip_cnt_d;
  logic [10:0] pix_cnt_q, pix_cnt_d;
  logic [9:0]  line_cnt_q, line_cnt_d;
  logic [15:0] pdata_q, pdata_d;
  logic        de_q, de_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_valid_q, frame_valid_d;
  logic        geom_err_q, geom_err_d;

  logic vs_rise, vs_fall, hr_rise, hr_fall;
  logic capturing, phase_cur, err_set;

  always_comb begin
    cfg_meta_d    = cfg_done;
    cfg_sync_d    = cfg_meta_q;
    vs_d          = cmos_vsync;
    vs_prev_d     = vs_q;
    hr_d          = cmos_href;
    hr_prev_d     = hr_q;
    db_d          = cmos_db;
    state_d       = state_q;
    skip_cnt_d    = skip_cnt_q;
    byte0_d       = byte0_q;
    phase_d       = phase_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    pdata_d       = pdata_q;
    de_d          = 1'b0;
    frame_start_d = 1'b0;

    vs_rise = vs_q & ~vs_prev_q;
    vs_fall = ~vs_q & vs_prev_q;
    hr_rise = hr_q & ~hr_prev_q;
    hr_fall = ~hr_q & hr_prev_q;

    case (state_q)
      WAIT_CFG: begin
        skip_cnt_d = '0;
        if (cfg_sync_q) state_d = SKIP;
      end
      SKIP: begin
        if (skip_cnt_q >= SKIP_N) begin
          state_d = ARMED;
        end else if (vs_rise) begin
          skip_cnt_d = skip_cnt_q + 16'd1;
          if (skip_cnt_q + 16'd1 >= SKIP_N) state_d = ARMED;
        end
      end
      ARMED: begin
        if (vs_fall) begin
          state_d       = CAPTURE;
          frame_start_d = 1'b1;
        end
      end
      CAPTURE: begin
        if (vs_rise) state_d = ARMED;
      end
      default: state_d = WAIT_CFG;
    endcase

    // Losing sensor configuration aborts everything and forces a fresh skip sequence.
    if (!cfg_sync_q) begin
      state_d       = WAIT_CFG;
      skip_cnt_d    = '0;
      frame_start_d = 1'b0;
    end
    frame_valid_d = (state_d == CAPTURE);

    capturing = (state_q == CAPTURE) && cfg_sync_q;
    phase_cur = hr_rise ? 1'b0 : phase_q;
    if (hr_q) begin
      if (!phase_cur) begin
        byte0_d = db_q;
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        if (capturing) begin
          de_d    = 1'b1;
          pdata_d = pack_px(byte0_q, db_q);
        end
      end
    end

    if (hr_rise)                        pix_cnt_d = '0;
    else if (de_d && (pix_cnt_q != '1)) pix_cnt_d = pix_cnt_q + 11'd1;

    if (frame_start_d)                                  line_cnt_d = '0;
    else if (hr_fall && capturing && (line_cnt_q != '1)) line_cnt_d = line_cnt_q + 10'd1;

    // A dangling half pixel at line end is a malformed line even if the pixel count matches.
    err_set = capturing && ((hr_fall && ((pix_cnt_q != H_N) || phase_q)) ||
                            (vs_rise && (line_cnt_q != V_N)));
    if (frame_start_d) geom_err_d = 1'b0;
    else if (err_set)  geom_err_d = 1'b1;
    else               geom_err_d = geom_err_q;
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_CFG;
      cfg_meta_q    <= 1'b0;
      cfg_sync_q    <= 1'b0;
      vs_q          <= 1'b0;
      vs_prev_q     <= 1'b0;
      hr_q          <= 1'b0;
      hr_prev_q     <= 1'b0;
      db_q          <= '0;
      byte0_q       <= '0;
      phase_q       <= 1'b0;
      skip_cnt_q    <= '0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      pdata_q       <= '0;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      frame_valid_q <= 1'b0;
      geom_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cfg_meta_q    <= cfg_meta_d;
      cfg_sync_q    <= cfg_sync_d;
      vs_q          <= vs_d;
      vs_prev_q     <= vs_prev_d;
      hr_q          <= hr_d;
      hr_prev_q     <= hr_prev_d;
      db_q          <= db_d;
      byte0_q       <= byte0_d;
      phase_q       <= phase_d;
      skip_cnt_q    <= skip_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      pdata_q       <= pdata_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
      frame_valid_q <= frame_valid_d;
      geom_err_q    <= geom_err_d;
    end
  end

  assign pdata_o       = pdata_q;
  assign de_o          = de_q;
  assign frame_start_o = frame_start_q;
  assign frame_valid_o = frame_valid_q;
  assign geom_err_o    = geom_err_q;

endmodule

// File: tb/tb_cmos_capture.sv
// Bench for cmos_capture on a reduced 8x4 geometry with FRAME_SKIP=2; pixels tracked by a scoreboard.
module tb_cmos_capture;

  localparam int FS = 2;
  localparam int H  = 8;
  localparam int V  = 4;

  logic        clk = 1'b0;
  logic        rst_n, cfg_done, vs, hr;
  logic [7:0]  db;
  logic [15:0] pdata;
  logic        de, fs_o, fv, ge;

  always #5 clk = ~clk;

  cmos_capture #(.FRAME_SKIP(FS), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .cmos_pclk(clk), .rst_n(rst_n), .cfg_done(cfg_done), .cmos_vsync(vs),
    .cmos_href(hr), .cmos_db(db), .pdata_o(pdata), .de_o(de),
    .frame_start_o(fs_o), .frame_valid_o(fv), .geom_err_o(ge)
  );

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] exp;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          de_cnt = 0;
  int          fs_cnt = 0;
  logic [15:0] sb[$];
  logic [15:0] last_px = '0;
  logic [15:0] exp_px;
  bit          lat_arm = 0;
  int          lat_cyc = 0;
  logic [15:0] lat_px = '0;
  int          t_b1 = 0;
  vec_t        tbl[H];

  function automatic logic [15:0] px(input logic [7:0] b0, input logic [7:0] b1);
`ifdef CMOS_CAPTURE_BYTESWAP_EN
    return {b1, b0};
`else
    return {b0, b1};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fs_o) fs_cnt++;
    if (de) begin
      de_cnt++;
      if (lat_arm) begin
        lat_cyc = cyc;
        lat_px  = pdata;
        lat_arm = 0;
      end
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL de_unexpected: de_o=1 pdata_o=0x%0h at cycle %0d, no pixel pending", pdata, cyc);
      end else begin
        exp_px = sb.pop_front();
        check("pixel", {16'h0, pdata}, {16'h0, exp_px});
        last_px = exp_px;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] seed, input bit cap);
    logic [7:0] b0;
    logic [7:0] b;
    b0 = '0;
    for (int i = 0; i < nbytes; i++) begin
      b = seed + 8'(i * 37);
      if (i % 2 == 0) b0 = b;
      else if (cap) sb.push_back(px(b0, b));
      hr = 1'b1;
      db = b;
      tick();
    end
    hr = 1'b0;
    db = 8'h00;
    repeat (4) tick();
  endtask

  task automatic vs_pulse();
    vs = 1'b1;
    repeat (3) tick();
    vs = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_frame(input int nlines, input bit cap);
    for (int l = 0; l < nlines; l++) send_line(2 * H, 8'($urandom), cap);
    vs_pulse();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pdata"}, {16'h0, pdata}, 32'h0);
    check({tag, "_de"}, {31'h0, de}, 32'h0);
    check({tag, "_frame_start"}, {31'h0, fs_o}, 32'h0);
    check({tag, "_frame_valid"}, {31'h0, fv}, 32'h0);
    check({tag, "_geom_err"}, {31'h0, ge}, 32'h0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'hF8, 8'h1F, 16'h0};
    tbl[1] = '{8'h00, 8'h00, 16'h0};
    tbl[2] = '{8'hFF, 8'hFF, 16'h0};
    tbl[3] = '{8'h12, 8'h34, 16'h0};
    tbl[4] = '{8'h80, 8'h01, 16'h0};
    tbl[5] = '{8'h07, 8'hE0, 16'h0};
    tbl[6] = '{8'hAA, 8'h55, 16'h0};
    tbl[7] = '{8'h5A, 8'hA5, 16'h0};
    for (int i = 0; i < H; i++) tbl[i].exp = px(tbl[i].b0, tbl[i].b1);

    rst_n = 1'b0; cfg_done = 1'b0; vs = 1'b0; hr = 1'b0; db = 8'h00;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();
    cfg_done = 1'b1;
    repeat (4) tick();
    check("skip_fv", {31'h0, fv}, 32'h0);

    // Frames 1-2 are discarded, frame 3 is the first forwarded frame.
    send_frame(V, 0);
    send_frame(V, 0);
    check("skip_no_de", de_cnt, 0);
    check("fs_after_skip", fs_cnt, 1);
    check("capture_fv", {31'h0, fv}, 32'h1);

    lat_arm = 1;
    for (int i = 0; i < H; i++) begin
      hr = 1'b1;
      db = tbl[i].b0;
      tick();
      db = tbl[i].b1;
      sb.push_back(tbl[i].exp);
      if (i == 0) t_b1 = cyc;
      tick();
    end
    hr = 1'b0;
    db = 8'h00;
    repeat (4) tick();
`ifdef CMOS_CAPTURE_BYTESWAP_EN
    check("first_px_value", {16'h0, lat_px}, 32'h1FF8);
`else
    check("first_px_value", {16'h0, lat_px}, 32'hF81F);
`endif
    check("first_px_latency", lat_cyc - t_b1, 2);
    for (int l = 1; l < V; l++) send_line(2 * H, 8'($urandom), 1);
    vs_pulse();
    check("frame3_strobes", de_cnt, H * V);
    check("frame3_drained", sb.size(), 0);
    check("frame3_geom", {31'h0, ge}, 32'h0);

    de_cnt = 0;
    send_frame(V, 1);
    check("frame4_strobes", de_cnt, H * V);
    check("frame4_geom", {31'h0, ge}, 32'h0);
    check("pdata_hold", {16'h0, pdata}, {16'h0, last_px});
    check("fs_count", fs_cnt, 3);

    // Odd-length line: trailing byte dropped, error raised, cleared by next frame start.
    de_cnt = 0;
    send_line(2 * H + 1, 8'h3C, 1);
    check("odd_line_strobes", de_cnt, H);
    check("odd_line_err", {31'h0, ge}, 32'h1);
    for (int l = 1; l < V; l++) send_line(2 * H, 8'($urandom), 1);
    check("odd_err_sticky", {31'h0, ge}, 32'h1);
    vs_pulse();
    check("odd_err_cleared", {31'h0, ge}, 32'h0);
    check("frame5_strobes", de_cnt, H * V);

    // Short frame: error appears at the vsync rising edge.
    de_cnt = 0;
    for (int l = 0; l < V - 1; l++) send_line(2 * H, 8'($urandom), 1);
    check("short_pre_err", {31'h0, ge}, 32'h0);
    vs = 1'b1;
    repeat (3) tick();
    check("short_frame_err", {31'h0, ge}, 32'h1);
    vs = 1'b0;
    repeat (3) tick();
    check("short_err_cleared", {31'h0, ge}, 32'h0);

    // cfg_done dropped mid-frame, then skip sequence re-applied.
    de_cnt = 0;
    send_line(2 * H, 8'h11, 1);
    send_line(2 * H, 8'h22, 1);
    cfg_done = 1'b0;
    repeat (4) tick();
    check("cfg_drop_fv", {31'h0, fv}, 32'h0);
    check("cfg_drop_de", {31'h0, de}, 32'h0);
    send_line(2 * H, 8'h33, 0);
    check("cfg_drop_strobes", de_cnt, 2 * H);
    cfg_done = 1'b1;
    repeat (4) tick();
    send_line(2 * H, 8'h44, 0);
    vs_pulse();
    check("reskip_fv", {31'h0, fv}, 32'h0);
    send_frame(V, 0);
    check("rearm_fv", {31'h0, fv}, 32'h1);
    de_cnt = 0;
    send_frame(V, 1);
    check("recapture_strobes", de_cnt, H * V);
    check("recapture_geom", {31'h0, ge}, 32'h0);

    // Asynchronous reset in the middle of a forwarded line.
    de_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      hr = 1'b1;
      db = 8'(8'h40 + i);
      if (i % 2 == 1) sb.push_back(px(8'(8'h40 + i - 1), 8'(8'h40 + i)));
      tick();
    end
    db = 8'h46;
    tick();
    db = 8'h47;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    hr = 1'b0;
    db = 8'h00;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rst_strobes", de_cnt, 3);
    check("rst_drained", sb.size(), 0);
    send_line(2 * H, 8'h55, 0);
    send_line(2 * H, 8'h66, 0);
    check("post_rst_fv", {31'h0, fv}, 32'h0);
    vs_pulse();
    send_frame(V, 0);
    check("post_rst_skip_strobes", de_cnt, 3);
    de_cnt = 0;
    send_frame(V, 1);
    check("post_rst_strobes", de_cnt, H * V);
    check("final_drained", sb.size(), 0);
    check("final_geom", {31'h0, ge}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
